// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - comparator result codes and legality helper shared by comparator and filter
package cmp_pkg;

  localparam logic [2:0] CMP_GT   = 3'b100;
  localparam logic [2:0] CMP_EQ   = 3'b010;
  localparam logic [2:0] CMP_LT   = 3'b001;
  localparam logic [2:0] CMP_NONE = 3'b000;

  function automatic logic is_legal_cmp(input logic [2:0] code);
    return (code == CMP_GT) || (code == CMP_EQ) || (code == CMP_LT);
  endfunction

endpackage

// File: rtl/cmp_result_filter_if.sv
// rtl/cmp_result_filter_if.sv - sample/result bundle between comparator side and filter
// Illegal_cnt exists only when CMPF_ILLEGAL_CNT_EN is defined.
interface cmp_result_filter_if;

  logic       In_valid;
  logic [2:0] R_in;
  logic       Clear;
  logic [2:0] F_out;
  logic       Known;
  logic       Changed;
  logic       Illegal;
  logic [7:0] Change_cnt;
`ifdef CMPF_ILLEGAL_CNT_EN
  logic [7:0] Illegal_cnt;
`endif

`ifdef CMPF_ILLEGAL_CNT_EN
  modport master (output In_valid, R_in, Clear,
                  input  F_out, Known, Changed, Illegal, Change_cnt, Illegal_cnt);
  modport slave  (input  In_valid, R_in, Clear,
                  output F_out, Known, Changed, Illegal, Change_cnt, Illegal_cnt);
`else
  modport master (output In_valid, R_in, Clear,
                  input  F_out, Known, Changed, Illegal, Change_cnt);
  modport slave  (input  In_valid, R_in, Clear,
                  output F_out, Known, Changed, Illegal, Change_cnt);
`endif

endinterface

// File: rtl/sat_counter8.sv
// rtl/sat_counter8.sv - 8-bit event counter that sticks at 255
module sat_counter8 (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] cnt
);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != 8'hFF)) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/cmp_result_filter.sv
// rtl/cmp_result_filter.sv - debounces comparator one-hot results, flags illegal codes, counts changes
// Optional Illegal_cnt output enabled by CMPF_ILLEGAL_CNT_EN.
module cmp_result_filter
  import cmp_pkg::*;
#(
  parameter int STABLE_CNT = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  cmp_result_filter_if.slave  bus
);

  localparam int              CNT_W   = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(STABLE_CNT);

  logic [2:0]       cand;
  logic [2:0]       f_out;
  logic [CNT_W-1:0] run;
  logic [CNT_W-1:0] run_nxt;
  logic             changed;
  logic             illegal;
  logic             legal;
  logic             commit;
  logic             illegal_hit;

  always_comb begin
    legal   = is_legal_cmp(bus.R_in);
    run_nxt = RUN_MAX;
    if (bus.R_in != cand) begin
      run_nxt = CNT_W'(1);
    end else if (run != RUN_MAX) begin
      run_nxt = run + 1'b1;
    end
    commit      = bus.In_valid && legal && (run_nxt == RUN_MAX) && (bus.R_in != f_out);
    illegal_hit = bus.In_valid && (bus.R_in != CMP_NONE) && !legal;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      f_out   <= CMP_NONE;
      cand    <= CMP_NONE;
      run     <= '0;
      changed <= 1'b0;
      illegal <= 1'b0;
    end else if (bus.Clear) begin
      f_out   <= CMP_NONE;
      cand    <= CMP_NONE;
      run     <= '0;
      changed <= 1'b0;
      illegal <= 1'b0;
    end else begin
      changed <= commit;
      illegal <= illegal_hit;
      if (bus.In_valid) begin
        // No-result and multi-hot samples both break the run; only multi-hot is an error.
        if (!legal) begin
          cand <= CMP_NONE;
          run  <= '0;
        end else begin
          cand <= bus.R_in;
          run  <= run_nxt;
          if (commit) begin
            f_out <= bus.R_in;
          end
        end
      end
    end
  end

  assign bus.F_out   = f_out;
  assign bus.Known   = (f_out != CMP_NONE);
  assign bus.Changed = changed;
  assign bus.Illegal = illegal;

  sat_counter8 u_change_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .inc   (commit),
    .clr   (bus.Clear),
    .cnt   (bus.Change_cnt)
  );

`ifdef CMPF_ILLEGAL_CNT_EN
  sat_counter8 u_illegal_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .inc   (illegal_hit),
    .clr   (bus.Clear),
    .cnt   (bus.Illegal_cnt)
  );
`endif

endmodule

// File: tb/tb_cmp_result_filter.sv
// tb/tb_cmp_result_filter.sv - directed checks of cmp_result_filter at STABLE_CNT 4 and 1
module tb_cmp_result_filter;

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;

  cmp_result_filter_if a_if ();
  cmp_result_filter_if b_if ();

  cmp_result_filter #(.STABLE_CNT(4)) u_dut4 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (a_if.slave)
  );

  cmp_result_filter #(.STABLE_CNT(1)) u_dut1 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (b_if.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic a_sample(input logic [2:0] r);
    a_if.In_valid = 1'b1;
    a_if.R_in     = r;
    @(posedge Clk);
    #1;
    a_if.In_valid = 1'b0;
    a_if.R_in     = 3'b000;
  endtask

  task automatic b_sample(input logic [2:0] r);
    b_if.In_valid = 1'b1;
    b_if.R_in     = r;
    @(posedge Clk);
    #1;
    b_if.In_valid = 1'b0;
    b_if.R_in     = 3'b000;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic a_zero(input string tag);
    chk({tag, "_f"},   32'(a_if.F_out), 32'h0);
    chk({tag, "_k"},   32'(a_if.Known), 32'h0);
    chk({tag, "_ch"},  32'(a_if.Changed), 32'h0);
    chk({tag, "_il"},  32'(a_if.Illegal), 32'h0);
    chk({tag, "_cnt"}, 32'(a_if.Change_cnt), 32'h0);
  endtask

  logic [2:0] seq2 [8];
  int         pulses;

  initial begin
    checks = 0;
    errors = 0;
    Reset = 1'b0;
    a_if.In_valid = 1'b0; a_if.R_in = 3'b000; a_if.Clear = 1'b0;
    b_if.In_valid = 1'b0; b_if.R_in = 3'b000; b_if.Clear = 1'b0;
    idle(2);
    a_zero("rst");
    Reset = 1'b1;
    idle(1);

    // First commit from unknown
    repeat (3) a_sample(3'b100);
    chk("t1_pre", 32'(a_if.F_out), 32'h0);
    a_sample(3'b100);
    chk("t1_f",   32'(a_if.F_out), 32'h4);
    chk("t1_ch",  32'(a_if.Changed), 32'h1);
    chk("t1_cnt", 32'(a_if.Change_cnt), 32'd1);
    chk("t1_k",   32'(a_if.Known), 32'h1);
    idle(1);
    chk("t1_ch_off", 32'(a_if.Changed), 32'h0);

    // Interrupted run only commits on the 8th sample
    repeat (4) a_sample(3'b001);
    chk("t2_setup", 32'(a_if.F_out), 32'h1);
    seq2 = '{3'b100, 3'b100, 3'b100, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      a_sample(seq2[i]);
      pulses += int'(a_if.Changed);
      if (i == 6) chk("t2_pre", 32'(a_if.F_out), 32'h1);
    end
    chk("t2_f",      32'(a_if.F_out), 32'h4);
    chk("t2_pulses", 32'(pulses), 32'd1);
    chk("t2_cnt",    32'(a_if.Change_cnt), 32'd3);
    a_sample(3'b100);
    chk("t2_sat_ch",  32'(a_if.Changed), 32'h0);
    chk("t2_sat_cnt", 32'(a_if.Change_cnt), 32'd3);

    // Gaps between valid samples do not break a run
    for (int i = 0; i < 4; i++) begin
      a_sample(3'b010);
      if (i == 2) chk("t3_pre", 32'(a_if.F_out), 32'h4);
      if (i < 3) idle(3);
    end
    chk("t3_f",   32'(a_if.F_out), 32'h2);
    chk("t3_cnt", 32'(a_if.Change_cnt), 32'd4);

    // Illegal code mid-run restarts it
    repeat (2) a_sample(3'b001);
    a_sample(3'b110);
    chk("t4_il", 32'(a_if.Illegal), 32'h1);
    idle(1);
    chk("t4_il_off", 32'(a_if.Illegal), 32'h0);
    repeat (3) a_sample(3'b001);
    chk("t4_pre", 32'(a_if.F_out), 32'h2);
    a_sample(3'b001);
    chk("t4_f",   32'(a_if.F_out), 32'h1);
    chk("t4_cnt", 32'(a_if.Change_cnt), 32'd5);
`ifdef CMPF_ILLEGAL_CNT_EN
    chk("t4_ilcnt", 32'(a_if.Illegal_cnt), 32'd1);
`endif

    // A valid no-result sample breaks the run without an error
    repeat (2) a_sample(3'b100);
    a_sample(3'b000);
    chk("t7_il", 32'(a_if.Illegal), 32'h0);
    repeat (3) a_sample(3'b100);
    chk("t7_pre", 32'(a_if.F_out), 32'h1);
    a_sample(3'b100);
    chk("t7_f", 32'(a_if.F_out), 32'h4);

    // Reset mid-run abandons the run
    repeat (3) a_sample(3'b010);
    Reset = 1'b0;
    #1;
    a_zero("t6_rst");
    idle(1);
    Reset = 1'b1;
    repeat (3) a_sample(3'b010);
    chk("t6_pre", 32'(a_if.F_out), 32'h0);
    a_sample(3'b010);
    chk("t6_f",   32'(a_if.F_out), 32'h2);
    chk("t6_cnt", 32'(a_if.Change_cnt), 32'd1);

    // Clear wins over a simultaneous sample
    repeat (3) a_sample(3'b100);
    a_if.Clear = 1'b1;
    a_sample(3'b100);
    a_if.Clear = 1'b0;
    a_zero("t6_clr");
`ifdef CMPF_ILLEGAL_CNT_EN
    chk("t6_clr_ilcnt", 32'(a_if.Illegal_cnt), 32'd0);
`endif
    repeat (3) a_sample(3'b100);
    chk("t6_clr_pre", 32'(a_if.F_out), 32'h0);
    a_sample(3'b100);
    chk("t6_clr_f",   32'(a_if.F_out), 32'h4);
    chk("t6_clr_cnt", 32'(a_if.Change_cnt), 32'd1);

    // STABLE_CNT = 1: every differing sample commits; counter saturates
    b_sample(3'b100);
    chk("t5_first_f",  32'(b_if.F_out), 32'h4);
    chk("t5_first_ch", 32'(b_if.Changed), 32'h1);
    for (int i = 1; i < 300; i++) begin
      b_sample((i % 2) ? 3'b001 : 3'b100);
      if (i == 253) chk("t5_cnt254", 32'(b_if.Change_cnt), 32'd254);
      if (i == 254) chk("t5_cnt255", 32'(b_if.Change_cnt), 32'd255);
    end
    chk("t5_cnt_sat", 32'(b_if.Change_cnt), 32'd255);
    chk("t5_last_ch", 32'(b_if.Changed), 32'h1);
    chk("t5_last_f",  32'(b_if.F_out), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmp_result_filter.md
Name: cmp_result_filter

Overview:
- Sits directly downstream of the 8-bit magnitude comparator and consumes its registered one-hot result R[2:0] (100 = A>B, 010 = A==B, 001 = A<B, 000 = no result / reset).
- Debounces the result stream: the filtered output changes only after STABLE_CNT consecutive valid, identical, legal samples.
- Flags illegal codes, pulses on every filtered change, and keeps a saturating change counter for the control/status logic.

Parameters:
- STABLE_CNT, 4, consecutive identical valid samples needed to commit a new result; legal range 1..255.
- CNT_W, $clog2(STABLE_CNT+1), derived localparam giving the run-counter width; not overridable.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- In_valid  in  1  R_in carries a fresh sample this cycle.
- R_in  in  3  comparator result code.
- Clear  in  1  synchronous clear of filter state and counters.
- F_out  out  3  filtered one-hot result; 000 = unknown.
- Known  out  1  high when F_out != 000.
- Changed  out  1  one-cycle pulse, high in the cycle after F_out updates.
- Illegal  out  1  one-cycle pulse, high for an illegal valid sample.
- Change_cnt  out  8  number of F_out updates, saturating at 255.

Behaviour:
- Reset low drives, asynchronously: F_out = 000, Known = 0, Changed = 0, Illegal = 0, Change_cnt = 0, internal cand = 000, run = 0.
- All other updates occur on the rising edge of Clk. Priority order: Reset, then Clear, then In_valid.
- Clear = 1: same values as reset. Clear wins over a simultaneous In_valid, which is dropped.
- In_valid = 0: all state holds and pulses deassert. Gaps do not break a run.
- Valid sample 000: cand = 000, run = 0, no error, F_out holds.
- Valid sample with a multi-hot code (011, 101, 110, 111): Illegal pulses, cand = 000, run = 0, F_out holds.
- Valid legal sample C with C != cand: cand = C, run = 1.
- Valid legal sample C with C == cand: run = min(run+1, STABLE_CNT).
- Commit rule: when the updated run equals STABLE_CNT and C != F_out, F_out = C on that same edge.
  - Changed is registered and is high for exactly the next cycle.
  - Change_cnt increments by one, saturating at 255.
  - The first commit from 000 counts as a change.
- Latency: F_out reflects the STABLE_CNT-th consecutive sample one clock after it is presented. With STABLE_CNT = 1 every legal differing sample commits immediately.
- Saturation: run saturates at STABLE_CNT. Further identical samples cause no re-commit and no Changed pulse.
- Known is combinational from F_out.
- Reset asserted mid-run abandons the run. After release, STABLE_CNT fresh samples are required before any commit.

Optional Feature:
- Macro: CMPF_ILLEGAL_CNT_EN.
- Defined: adds output Illegal_cnt[7:0].
  - Counts Illegal pulses, saturating at 255.
  - Zeroed by Reset and by Clear.
- Undefined: the port and its counter do not exist. The Illegal pulse is unchanged.

Decomposition:
- Shared package cmp_pkg holds:
  - Code constants CMP_GT = 3'b100, CMP_EQ = 3'b010, CMP_LT = 3'b001, CMP_NONE = 3'b000.
  - Function is_legal_cmp(code), true for the three one-hot codes.
- Comparator and filter both import cmp_pkg.
- One sub-module, sat_counter8: 8-bit, with inc, clr and async active-low reset, saturating at 255. It is instantiated for Change_cnt and, when CMPF_ILLEGAL_CNT_EN is defined, for Illegal_cnt.

Test Plan:
- STABLE_CNT = 4; valid 100 for 4 cycles -> F_out = 100 after the 4th edge, Changed high for 1 cycle, Change_cnt = 1, Known = 1.
- Sequence 100, 100, 100, 010, 100, 100, 100, 100 with F_out = 001 -> no commit until the 8th sample; F_out = 100 then, Changed pulses exactly once.
- Valid 010 x4 with In_valid low 3 cycles between each sample -> F_out = 010 after the 4th valid sample; gaps ignored.
- Valid 110 mid-run of 001 (2 samples) -> Illegal pulses, run restarts; next 4 x 001 are required to commit; Illegal_cnt = 1 when CMPF_ILLEGAL_CNT_EN is defined.
- Alternate 100 and 001 commits 300 times with STABLE_CNT = 1 -> Change_cnt saturates at 255, no wrap.
- Reset low for 1 cycle after 3 of 4 samples, and separately Clear together with In_valid -> all outputs 0, the simultaneous sample is dropped, and a fresh 4-sample run is needed.
